// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the multi-cycle CPU control sequencer.
// Holds the FSM state encoding, opcode classes and strobe bundle.
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH_A,
    S_FETCH_R,
    S_LOAD_IR,
    S_DECODE,
    S_EX_ALU,
    S_MEM_AL,
    S_MEM_AS,
    S_MEM_R,
    S_MEM_WB,
    S_MEM_W,
    S_PC_INC,
    S_HALT
  } state_t;

  typedef enum logic [2:0] {
    C_NOP,
    C_ALU,
    C_LD,
    C_ST,
    C_HALT,
    C_ILL
  } op_class_t;

  localparam logic [5:0] OP_NOP  = 6'b000000;
  localparam logic [5:0] OP_LD   = 6'b000001;
  localparam logic [5:0] OP_ST   = 6'b000010;
  localparam logic [5:0] OP_HALT = 6'b000011;
  localparam int         ALU_BIT = 5;

  typedef struct packed {
    logic pcFetch;
    logic pcEn;
    logic irEn;
    logic marEn;
    logic ldEn;
    logic stEn;
    logic mdrEn;
    logic rd;
    logic wr;
    logic wEn;
  } strobes_t;

  function automatic op_class_t classify(
    input logic [5:0] op
  );
    op_class_t c;
    unique case (1'b1)
      op[ALU_BIT]:     c = C_ALU;
      (op == OP_NOP):  c = C_NOP;
      (op == OP_LD):   c = C_LD;
      (op == OP_ST):   c = C_ST;
      (op == OP_HALT): c = C_HALT;
      default:         c = C_ILL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/cpu_control_unit_if.sv
// Datapath-facing bundle: IR opcode in, datapath strobes out.
// master = control unit, slave = datapath.
interface cpu_control_unit_if;

  logic [5:0] opcode;
  logic       pcFetch;
  logic       pcEn;
  logic       irEn;
  logic       marEn;
  logic       ldEn;
  logic       stEn;
  logic       mdrEn;
  logic       rd;
  logic       wr;
  logic       wEn;

  modport master (
    input  opcode,
    output pcFetch, pcEn, irEn, marEn,
    output ldEn, stEn, mdrEn,
    output rd, wr, wEn
  );

  modport slave (
    output opcode,
    input  pcFetch, pcEn, irEn, marEn,
    input  ldEn, stEn, mdrEn,
    input  rd, wr, wEn
  );

endinterface

// File: rtl/cpu_control_unit_timer.sv
// RAM latency wait timer shared by all memory wait states.
// Loaded on wait-state entry; done while the count is zero.
module mem_wait_timer #(
  parameter int MEM_LAT = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic done
);

  localparam int W = $clog2(MEM_LAT + 1);
  localparam logic [W-1:0] INIT = W'(MEM_LAT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= INIT;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/cpu_control_unit.sv
// Multi-cycle control FSM: fetch, decode, execute, PC increment.
// Strobes are Moore outputs of the state register.
module cpu_control_unit
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_LAT = 2,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  cpu_control_unit_if.master bus,
  output logic               halted,
  output logic               illegal,
  output logic [CNT_W-1:0]   retired
);

  state_t    state;
  state_t    nxt;
  op_class_t cls;
  strobes_t  st;
  logic      done;
  logic      load;
  logic      nxt_wait;

  assign cls = classify(bus.opcode);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      retired <= '0;
    end else begin
      state <= nxt;
      if (state == S_PC_INC) begin
        retired <= retired + CNT_W'(1);
      end
    end
  end

  assign nxt_wait = (nxt == S_FETCH_R) ||
                    (nxt == S_MEM_R) ||
                    (nxt == S_MEM_W);
  assign load = nxt_wait && (nxt != state);

  mem_wait_timer #(
    .MEM_LAT(MEM_LAT)
  ) u_timer (
    .clk  (clk),
    .reset(reset),
    .load (load),
    .done (done)
  );

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:    if (run) nxt = S_FETCH_A;
      S_FETCH_A: nxt = S_FETCH_R;
      S_FETCH_R: if (done) nxt = S_LOAD_IR;
      S_LOAD_IR: nxt = S_DECODE;
      S_DECODE: begin
        unique case (cls)
          C_ALU:   nxt = S_EX_ALU;
          C_LD:    nxt = S_MEM_AL;
          C_ST:    nxt = S_MEM_AS;
          C_HALT:  nxt = S_HALT;
          default: nxt = S_PC_INC;
        endcase
      end
      S_EX_ALU:  nxt = S_PC_INC;
      S_MEM_AL:  nxt = S_MEM_R;
      S_MEM_AS:  nxt = S_MEM_W;
      S_MEM_R:   if (done) nxt = S_MEM_WB;
      S_MEM_WB:  nxt = S_PC_INC;
      S_MEM_W:   if (done) nxt = S_PC_INC;
      S_PC_INC:  nxt = run ? S_FETCH_A : S_IDLE;
      S_HALT:    nxt = S_HALT;
      default:   nxt = S_IDLE;
    endcase
  end

  always_comb begin
    st = '0;
    case (state)
      S_FETCH_A: begin
        st.pcFetch = 1'b1;
        st.marEn   = 1'b1;
      end
      S_FETCH_R: begin
        st.pcFetch = 1'b1;
        st.rd      = 1'b1;
      end
      S_LOAD_IR: begin
        st.pcFetch = 1'b1;
        st.rd      = 1'b1;
        st.irEn    = 1'b1;
      end
      S_EX_ALU: st.wEn = 1'b1;
      S_MEM_AL: begin
        st.marEn = 1'b1;
        st.mdrEn = 1'b1;
        st.ldEn  = 1'b1;
      end
      S_MEM_AS: begin
        st.marEn = 1'b1;
        st.mdrEn = 1'b1;
        st.stEn  = 1'b1;
      end
      S_MEM_R: begin
        st.rd    = 1'b1;
        st.ldEn  = 1'b1;
        st.mdrEn = 1'b1;
      end
      S_MEM_WB: begin
        st.ldEn  = 1'b1;
        st.mdrEn = 1'b1;
        st.wEn   = 1'b1;
      end
      S_MEM_W: begin
        st.wr    = 1'b1;
        st.stEn  = 1'b1;
        st.mdrEn = 1'b1;
      end
      S_PC_INC: st.pcEn = 1'b1;
      default:  st = '0;
    endcase
  end

  assign bus.pcFetch = st.pcFetch;
  assign bus.pcEn    = st.pcEn;
  assign bus.irEn    = st.irEn;
  assign bus.marEn   = st.marEn;
  assign bus.ldEn    = st.ldEn;
  assign bus.stEn    = st.stEn;
  assign bus.mdrEn   = st.mdrEn;
  assign bus.rd      = st.rd;
  assign bus.wr      = st.wr;
  assign bus.wEn     = st.wEn;

  assign halted  = (state == S_HALT);
  assign illegal = (state == S_DECODE) && (cls == C_ILL);

endmodule

// File: tb/tb_cpu_control_unit.sv
// Bench for cpu_control_unit: strobe traces against a queue of
// expected vectors, with MEM_LAT=2 and MEM_LAT=3 instances.
module tb_cpu_control_unit;

  localparam logic [11:0] B_PCF = 12'h800;
  localparam logic [11:0] B_PCE = 12'h400;
  localparam logic [11:0] B_IR  = 12'h200;
  localparam logic [11:0] B_MAR = 12'h100;
  localparam logic [11:0] B_LD  = 12'h080;
  localparam logic [11:0] B_ST  = 12'h040;
  localparam logic [11:0] B_MDR = 12'h020;
  localparam logic [11:0] B_RD  = 12'h010;
  localparam logic [11:0] B_WR  = 12'h008;
  localparam logic [11:0] B_WEN = 12'h004;
  localparam logic [11:0] B_HLT = 12'h002;
  localparam logic [11:0] B_ILL = 12'h001;

  typedef struct {
    logic [5:0] op;
    bit         sel;
    int         cycles;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic run = 1'b0;
  bit   sel = 1'b0;

  logic        halted2, illegal2, halted3, illegal3;
  logic [15:0] ret2, ret3;

  int checks = 0;
  int failures = 0;
  logic [11:0] exp_q[$];

  always #5 clk = ~clk;

  cpu_control_unit_if if2();
  cpu_control_unit_if if3();

  cpu_control_unit #(.MEM_LAT(2), .CNT_W(16)) u2 (
    .clk    (clk),
    .reset  (reset),
    .run    (run),
    .bus    (if2),
    .halted (halted2),
    .illegal(illegal2),
    .retired(ret2)
  );

  cpu_control_unit #(.MEM_LAT(3), .CNT_W(16)) u3 (
    .clk    (clk),
    .reset  (reset),
    .run    (run),
    .bus    (if3),
    .halted (halted3),
    .illegal(illegal3),
    .retired(ret3)
  );

  wire [11:0] v2 = {if2.pcFetch, if2.pcEn, if2.irEn,
    if2.marEn, if2.ldEn, if2.stEn, if2.mdrEn, if2.rd,
    if2.wr, if2.wEn, halted2, illegal2};
  wire [11:0] v3 = {if3.pcFetch, if3.pcEn, if3.irEn,
    if3.marEn, if3.ldEn, if3.stEn, if3.mdrEn, if3.rd,
    if3.wr, if3.wEn, halted3, illegal3};

  function automatic logic [11:0] obs();
    return sel ? v3 : v2;
  endfunction

  function automatic logic [15:0] ret();
    return sel ? ret3 : ret2;
  endfunction

  task automatic set_op(input logic [5:0] op);
    if2.opcode = op;
    if3.opcode = op;
  endtask

  task automatic chk(input string nm,
                     input logic [11:0] act,
                     input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp,
               $time);
    end
  endtask

  task automatic chk_int(input string nm,
                         input int act,
                         input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", nm, act,
               exp, $time);
    end
  endtask

  function automatic void push_trace(input logic [5:0] op,
                                     input int lat);
    bit is_alu = op[5];
    bit is_ld  = (op == 6'b000001);
    bit is_st  = (op == 6'b000010);
    bit is_nop = (op == 6'b000000);
    exp_q.push_back(B_PCF | B_MAR);
    for (int k = 0; k < lat; k++) exp_q.push_back(B_PCF | B_RD);
    exp_q.push_back(B_PCF | B_RD | B_IR);
    exp_q.push_back((is_alu || is_ld || is_st || is_nop)
                    ? 12'h000 : B_ILL);
    if (is_alu) begin
      exp_q.push_back(B_WEN);
    end else if (is_ld) begin
      exp_q.push_back(B_MAR | B_MDR | B_LD);
      for (int k = 0; k < lat; k++)
        exp_q.push_back(B_RD | B_LD | B_MDR);
      exp_q.push_back(B_LD | B_MDR | B_WEN);
    end else if (is_st) begin
      exp_q.push_back(B_MAR | B_MDR | B_ST);
      for (int k = 0; k < lat; k++)
        exp_q.push_back(B_WR | B_ST | B_MDR);
    end
    exp_q.push_back(B_PCE);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    run = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic run_instr(input logic [5:0] op,
                           input bit s,
                           input int exp_cyc);
    int lat;
    int cyc;
    logic [11:0] v;
    logic [11:0] e;
    lat = s ? 3 : 2;
    cyc = 0;
    do_reset();
    sel = s;
    set_op(op);
    exp_q.delete();
    push_trace(op, lat);
    chk_int("ret_start", int'(ret()), 0);
    run = 1'b1;
    for (int i = 0; i < 40 && cyc == 0; i++) begin
      @(negedge clk);
      v = obs();
      if (i == 0) run = 1'b0;
      if (i == lat + 3) set_op(~op);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk($sformatf("trace op=%b i=%0d", op, i), v, e);
      end
      if (v[10]) cyc = i + 1;
    end
    chk_int($sformatf("cycles op=%b", op), cyc, exp_cyc);
    chk_int("trace_left", exp_q.size(), 0);
    @(negedge clk);
    chk("idle_after", obs(), 12'h000);
    chk_int("retired_one", int'(ret()), 1);
  endtask

  vec_t tbl[10];

  initial begin
    int pce_seen;
    bit found;

    tbl[0] = '{6'b100000, 1'b0, 7};
    tbl[1] = '{6'b111111, 1'b1, 8};
    tbl[2] = '{6'b000001, 1'b0, 10};
    tbl[3] = '{6'b000001, 1'b1, 12};
    tbl[4] = '{6'b000010, 1'b1, 11};
    tbl[5] = '{6'b000010, 1'b0, 9};
    tbl[6] = '{6'b000000, 1'b0, 6};
    tbl[7] = '{6'b000111, 1'b0, 6};
    tbl[8] = '{6'b010101, 1'b1, 7};
    tbl[9] = '{6'b000100, 1'b1, 7};

    set_op(6'b000000);
    #3;
    chk("reset_v2", v2, 12'h000);
    chk("reset_v3", v3, 12'h000);
    chk_int("reset_ret2", int'(ret2), 0);

    for (int t = 0; t < 10; t++)
      run_instr(tbl[t].op, tbl[t].sel, tbl[t].cycles);

    // HALT: parks for good, ignores run, only reset leaves it
    do_reset();
    sel = 1'b0;
    set_op(6'b000011);
    run = 1'b1;
    pce_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 4) chk("pre_halt", obs(), 12'h000);
      if (i == 5) chk("halt_entry", obs(), B_HLT);
      if (i > 8) run = ~run;
      if (obs() & B_PCE) pce_seen++;
    end
    chk("halt_hold", obs(), B_HLT);
    chk_int("halt_pce", pce_seen, 0);
    chk_int("halt_ret", int'(ret()), 0);
    do_reset();
    @(negedge clk);
    chk("halt_cleared", obs(), 12'h000);

    // Async reset while the LD after an ALU sits in MEM_R
    do_reset();
    sel = 1'b0;
    set_op(6'b100000);
    run = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (obs() & B_PCE) set_op(6'b000001);
      if (obs() == (B_RD | B_LD | B_MDR)) found = 1'b1;
    end
    chk_int("memr_found", int'(found), 1);
    chk_int("memr_ret", int'(ret()), 1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_strobes", obs(), 12'h000);
    chk_int("async_ret", int'(ret()), 0);
    @(negedge clk);
    run = 1'b0;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("post_reset_idle%0d", i), obs(),
          12'h000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks,
             failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
